// File: rtl/vid_in_axi4s_sync_coupler.sv
// Native video to AXI4-Stream coupler on a single clock. It uses an inferred FWFT FIFO,
// converts component widths, reports status, and drops the rest of a frame after an overflow.
module vid_in_axi4s_sync_coupler #(
  parameter int C_ADDR_WIDTH             = 10,
  parameter int C_PIXELS_PER_CLOCK       = 1,
  parameter int C_COMPONENTS_PER_PIXEL   = 3,
  parameter int C_NATIVE_COMPONENT_WIDTH = 8,
  parameter int C_M_AXIS_COMPONENT_WIDTH = 8,
  parameter int C_NATIVE_DATA_WIDTH      = 24,
  parameter int C_M_AXIS_TDATA_WIDTH     = 24,
  parameter int C_ALMOST_FULL_THRESH     = 2**C_ADDR_WIDTH - 16,
  parameter int C_RESYNC_ON_OVERFLOW     = 1
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              ACLKEN,
  input  logic                              VID_CE,
  input  logic [C_NATIVE_DATA_WIDTH+2:0]    FIFO_WR_DATA,
  input  logic                              FIFO_WR_EN,
  output logic [C_M_AXIS_TDATA_WIDTH+2:0]   FIFO_RD_DATA,
  output logic                              FIFO_VALID,
  input  logic                              FIFO_READY,
  output logic [C_ADDR_WIDTH:0]             FIFO_DATA_COUNT,
  output logic                              FIFO_FULL,
  output logic                              FIFO_ALMOST_FULL,
  output logic                              FIFO_OVERFLOW,
  output logic                              FIFO_UNDERFLOW,
  output logic                              DROPPING,
  output logic [1:0]                        STATUS_STICKY,
  input  logic                              STATUS_CLR
);

  localparam int DEPTH = 2**C_ADDR_WIDTH;
  localparam int NCOMP = C_PIXELS_PER_CLOCK * C_COMPONENTS_PER_PIXEL;
  localparam int NW    = C_NATIVE_COMPONENT_WIDTH;
  localparam int AW    = C_M_AXIS_COMPONENT_WIDTH;
  localparam int MW    = (NW < AW) ? NW : AW;
  localparam int PIXW  = NCOMP * MW;
  localparam int MEMW  = PIXW + 3;

  typedef enum logic {ST_NORMAL = 1'b0, ST_DROP = 1'b1} state_t;

  logic [MEMW-1:0]           r_mem [DEPTH];
  logic [MEMW-1:0]           r_rd_q;
  logic [C_ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [C_ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [C_ADDR_WIDTH:0]     r_count;
  logic                      r_valid;
  logic                      r_mid_line;
  logic                      r_ovf;
  logic                      r_unf;
  logic [1:0]                r_sticky;
  state_t                    r_state;
  state_t                    w_state_next;

  logic [PIXW-1:0]                 w_wr_pix;
  logic [MEMW-1:0]                 w_wr_word;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] w_rd_pix;
  logic [C_ADDR_WIDTH:0]           w_mem_cnt;
  logic w_full, w_sof, w_wr_try, w_wr_acc, w_rd_acc, w_ovf, w_unf, w_load;
  logic w_unused;

  assign w_full   = (r_count == (C_ADDR_WIDTH+1)'(DEPTH));
  assign w_sof    = FIFO_WR_DATA[C_NATIVE_DATA_WIDTH+2];
  assign w_wr_try = FIFO_WR_EN & VID_CE;
  assign w_wr_acc = w_wr_try & ~w_full & ((r_state == ST_NORMAL) | w_sof);
  assign w_rd_acc = r_valid & FIFO_READY & ACLKEN;
  // In DROP only a SOF counts as a real attempt, so plain drops stay silent.
  assign w_ovf    = w_wr_try & w_full & ((r_state == ST_NORMAL) | w_sof);
  assign w_unf    = FIFO_READY & ACLKEN & ~r_valid & r_mid_line;

  // The output stage holds one word, so the memory holds count minus that word.
  assign w_mem_cnt = r_count - {{C_ADDR_WIDTH{1'b0}}, r_valid};
  assign w_load    = (w_mem_cnt != '0) & (~r_valid | w_rd_acc);

  // Trimming keeps the MSBs of each component before the data is stored.
  for (genvar gi = 0; gi < NCOMP; gi++) begin : g_trim
    assign w_wr_pix[gi*MW +: MW] = FIFO_WR_DATA[gi*NW + (NW-MW) +: MW];
  end
  assign w_wr_word = {FIFO_WR_DATA[C_NATIVE_DATA_WIDTH+2:C_NATIVE_DATA_WIDTH], w_wr_pix};
  assign w_unused  = ^FIFO_WR_DATA;

  for (genvar gi = 0; gi < NCOMP; gi++) begin : g_pad
    if (AW > MW) begin : g_ext
      assign w_rd_pix[gi*AW +: AW] = {r_rd_q[gi*MW +: MW], {(AW-MW){1'b0}}};
    end else begin : g_same
      assign w_rd_pix[gi*AW +: AW] = r_rd_q[gi*MW +: MW];
    end
  end
  if (C_M_AXIS_TDATA_WIDTH > NCOMP*AW) begin : g_upper
    assign w_rd_pix[C_M_AXIS_TDATA_WIDTH-1:NCOMP*AW] = '0;
  end

  always_ff @(posedge ACLK) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= w_wr_word;
  end

  always_ff @(posedge ACLK) begin
    if (w_load) r_rd_q <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_mid_line <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_sticky   <= 2'b00;
      r_state    <= ST_NORMAL;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load)        r_valid <= 1'b1;
      else if (w_rd_acc) r_valid <= 1'b0;
      if (w_rd_acc) r_mid_line <= ~r_rd_q[PIXW+1];
      r_ovf       <= w_ovf;
      r_unf       <= w_unf;
      r_sticky[1] <= w_unf | (r_sticky[1] & ~STATUS_CLR);
      r_sticky[0] <= w_ovf | (r_sticky[0] & ~STATUS_CLR);
      r_state     <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_NORMAL: if (w_ovf && (C_RESYNC_ON_OVERFLOW != 0)) w_state_next = ST_DROP;
      ST_DROP:   if (w_wr_try && w_sof && !w_full)         w_state_next = ST_NORMAL;
      default:   w_state_next = ST_NORMAL;
    endcase
  end

  assign FIFO_RD_DATA     = r_valid ? {r_rd_q[MEMW-1:PIXW], w_rd_pix} : '0;
  assign FIFO_VALID       = r_valid;
  assign FIFO_DATA_COUNT  = r_count;
  assign FIFO_FULL        = w_full;
  assign FIFO_ALMOST_FULL = (r_count >= (C_ADDR_WIDTH+1)'(C_ALMOST_FULL_THRESH));
  assign FIFO_OVERFLOW    = r_ovf;
  assign FIFO_UNDERFLOW   = r_unf;
  assign DROPPING         = (r_state == ST_DROP);
  assign STATUS_STICKY    = r_sticky;

endmodule

// File: tb/tb_vid_in_axi4s_sync_coupler.sv
// Directed bench for the coupler: a vector table for streaming, plus sequences for
// full/resync, underflow, width conversion and asynchronous reset.
module tb_vid_in_axi4s_sync_coupler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aclken = 1'b1, vid_ce = 1'b1;
  logic [26:0] wr_data = '0;
  logic        wr_en = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [26:0] rd_data;
  logic        valid, full, afull, ovf, unf, dropping;
  logic [4:0]  cnt;
  logic [1:0]  sticky;

  // trim instance: 10-bit native -> 8-bit AXIS
  logic [12:0] t_wr = '0;
  logic        t_wr_en = 1'b0, t_ready = 1'b0;
  logic [10:0] t_rd;
  logic        t_valid;
  logic [4:0]  t_cnt;
  logic        t_unused_full, t_unused_af, t_unused_ovf, t_unused_unf, t_unused_drop;
  logic [1:0]  t_unused_st;
  // pad instance: 8-bit native -> 10-bit AXIS in 16-bit tdata
  logic [10:0] p_wr = '0;
  logic        p_wr_en = 1'b0, p_ready = 1'b0;
  logic [18:0] p_rd;
  logic        p_valid;
  logic [4:0]  p_cnt;
  logic        p_unused_full, p_unused_af, p_unused_ovf, p_unused_unf, p_unused_drop;
  logic [1:0]  p_unused_st;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vid_in_axi4s_sync_coupler #(
    .C_ADDR_WIDTH(4), .C_ALMOST_FULL_THRESH(12)
  ) u_dut (
    .ACLK(clk), .ARESETN(rst_n), .ACLKEN(aclken), .VID_CE(vid_ce),
    .FIFO_WR_DATA(wr_data), .FIFO_WR_EN(wr_en), .FIFO_RD_DATA(rd_data),
    .FIFO_VALID(valid), .FIFO_READY(ready), .FIFO_DATA_COUNT(cnt),
    .FIFO_FULL(full), .FIFO_ALMOST_FULL(afull), .FIFO_OVERFLOW(ovf),
    .FIFO_UNDERFLOW(unf), .DROPPING(dropping), .STATUS_STICKY(sticky),
    .STATUS_CLR(clr)
  );

  vid_in_axi4s_sync_coupler #(
    .C_ADDR_WIDTH(4), .C_COMPONENTS_PER_PIXEL(1), .C_NATIVE_COMPONENT_WIDTH(10),
    .C_M_AXIS_COMPONENT_WIDTH(8), .C_NATIVE_DATA_WIDTH(10), .C_M_AXIS_TDATA_WIDTH(8),
    .C_ALMOST_FULL_THRESH(12)
  ) u_trim (
    .ACLK(clk), .ARESETN(rst_n), .ACLKEN(aclken), .VID_CE(vid_ce),
    .FIFO_WR_DATA(t_wr), .FIFO_WR_EN(t_wr_en), .FIFO_RD_DATA(t_rd),
    .FIFO_VALID(t_valid), .FIFO_READY(t_ready), .FIFO_DATA_COUNT(t_cnt),
    .FIFO_FULL(t_unused_full), .FIFO_ALMOST_FULL(t_unused_af), .FIFO_OVERFLOW(t_unused_ovf),
    .FIFO_UNDERFLOW(t_unused_unf), .DROPPING(t_unused_drop), .STATUS_STICKY(t_unused_st),
    .STATUS_CLR(1'b0)
  );

  vid_in_axi4s_sync_coupler #(
    .C_ADDR_WIDTH(4), .C_COMPONENTS_PER_PIXEL(1), .C_NATIVE_COMPONENT_WIDTH(8),
    .C_M_AXIS_COMPONENT_WIDTH(10), .C_NATIVE_DATA_WIDTH(8), .C_M_AXIS_TDATA_WIDTH(16),
    .C_ALMOST_FULL_THRESH(12)
  ) u_pad (
    .ACLK(clk), .ARESETN(rst_n), .ACLKEN(aclken), .VID_CE(vid_ce),
    .FIFO_WR_DATA(p_wr), .FIFO_WR_EN(p_wr_en), .FIFO_RD_DATA(p_rd),
    .FIFO_VALID(p_valid), .FIFO_READY(p_ready), .FIFO_DATA_COUNT(p_cnt),
    .FIFO_FULL(p_unused_full), .FIFO_ALMOST_FULL(p_unused_af), .FIFO_OVERFLOW(p_unused_ovf),
    .FIFO_UNDERFLOW(p_unused_unf), .DROPPING(p_unused_drop), .STATUS_STICKY(p_unused_st),
    .STATUS_CLR(1'b0)
  );

  typedef struct {
    logic        wr_en;
    logic [26:0] wr;
    logic        ready;
    logic        exp_valid;
    logic [26:0] exp_rd;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [26:0] wd(input logic sof, input logic eol, input logic [23:0] p);
    return {sof, eol, 1'b0, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // streaming table: expectations hold after the edge that follows the applied inputs
    vecs[0]  = '{1'b1, wd(1,0,24'h1), 1'b1, 1'b0, 27'h0,          5'd1};
    vecs[1]  = '{1'b1, wd(0,0,24'h2), 1'b1, 1'b1, wd(1,0,24'h1),  5'd2};
    vecs[2]  = '{1'b1, wd(0,0,24'h3), 1'b1, 1'b1, wd(0,0,24'h2),  5'd2};
    vecs[3]  = '{1'b1, wd(0,0,24'h4), 1'b1, 1'b1, wd(0,0,24'h3),  5'd2};
    vecs[4]  = '{1'b1, wd(0,0,24'h5), 1'b1, 1'b1, wd(0,0,24'h4),  5'd2};
    vecs[5]  = '{1'b1, wd(0,0,24'h6), 1'b1, 1'b1, wd(0,0,24'h5),  5'd2};
    vecs[6]  = '{1'b1, wd(0,0,24'h7), 1'b1, 1'b1, wd(0,0,24'h6),  5'd2};
    vecs[7]  = '{1'b1, wd(0,1,24'h8), 1'b1, 1'b1, wd(0,0,24'h7),  5'd2};
    vecs[8]  = '{1'b0, 27'h0,         1'b1, 1'b1, wd(0,1,24'h8),  5'd1};
    vecs[9]  = '{1'b0, 27'h0,         1'b1, 1'b0, 27'h0,          5'd0};
    vecs[10] = '{1'b0, 27'h0,         1'b1, 1'b0, 27'h0,          5'd0};

    #12;
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_count", 64'(cnt), 64'd0);
    check("reset_flags", 64'({full, ovf, unf, dropping, sticky}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr; ready = vecs[i].ready;
      step();
      check($sformatf("pt%0d_valid", i), 64'(valid), 64'(vecs[i].exp_valid));
      check($sformatf("pt%0d_data", i), 64'(rd_data), 64'(vecs[i].exp_rd));
      check($sformatf("pt%0d_count", i), 64'(cnt), 64'(vecs[i].exp_cnt));
      check($sformatf("pt%0d_pulses", i), 64'({ovf, unf}), 64'd0);
    end

    // fill to full with the consumer stalled
    ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      wr_en = 1'b1; wr_data = wd(k == 1, 0, 24'h100 + 24'(k));
      step();
      check($sformatf("fill%0d_count", k), 64'(cnt), 64'(k));
      check($sformatf("fill%0d_full", k), 64'(full), 64'(k == 16));
      check($sformatf("fill%0d_afull", k), 64'(afull), 64'(k >= 12));
      check($sformatf("fill%0d_ovf", k), 64'(ovf), 64'd0);
    end
    check("fill_head", 64'({valid, rd_data}), 64'({1'b1, wd(1,0,24'h101)}));
    wr_data = wd(0, 0, 24'h111);
    step();
    check("ovf17_pulse", 64'(ovf), 64'd1);
    check("ovf17_drop", 64'(dropping), 64'd1);
    check("ovf17_count", 64'(cnt), 64'd16);
    check("ovf17_sticky", 64'(sticky), 64'b01);
    wr_en = 1'b0;
    step();
    check("ovf_one_cycle", 64'(ovf), 64'd0);

    // drain 4, then non-SOF writes are dropped until a SOF resynchronises
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("drain%0d_count", i), 64'(cnt), 64'(16 - i));
      check($sformatf("drain%0d_data", i), 64'(rd_data), 64'(wd(0, 0, 24'h101 + 24'(i))));
    end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = wd(0, 0, 24'h200 + 24'(i));
      step();
      check($sformatf("drop%0d_count", i), 64'(cnt), 64'd12);
      check($sformatf("drop%0d_state", i), 64'({dropping, ovf}), 64'b10);
    end
    wr_data = wd(1, 0, 24'h300);
    step();
    check("resync_count", 64'(cnt), 64'd13);
    check("resync_drop", 64'(dropping), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      wr_data = wd(0, 0, 24'h300 + 24'(i));
      step();
    end
    check("refill_count", 64'(cnt), 64'd16);
    check("refill_full", 64'(full), 64'd1);

    // write and read in the same cycle at full; the overflow pulse beats the clear
    wr_data = wd(0, 0, 24'h400); ready = 1'b1; clr = 1'b1;
    step();
    check("simul_ovf", 64'(ovf), 64'd1);
    check("simul_count", 64'(cnt), 64'd15);
    check("simul_data", 64'(rd_data), 64'(wd(0, 0, 24'h106)));
    check("simul_sticky", 64'(sticky), 64'b01);
    check("simul_drop", 64'(dropping), 64'd1);
    wr_en = 1'b0; ready = 1'b0; clr = 1'b0;

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(valid), 64'd0);
    check("arst_count", 64'(cnt), 64'd0);
    check("arst_flags", 64'({full, dropping, sticky, rd_data}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // underflow: a non-EOL word leaves the line open
    wr_en = 1'b1; wr_data = wd(0, 0, 24'h500);
    step();
    check("post_rst_accept", 64'(cnt), 64'd1);
    wr_en = 1'b0;
    step();
    check("unf_head", 64'({valid, rd_data}), 64'({1'b1, wd(0,0,24'h500)}));
    ready = 1'b1;
    step();
    check("unf_read", 64'({valid, cnt, unf}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("unf_pulse%0d", i), 64'(unf), 64'd1);
    end
    ready = 1'b0;
    step();
    check("unf_stop", 64'(unf), 64'd0);
    check("unf_sticky", 64'(sticky), 64'b10);
    clr = 1'b1;
    step();
    check("sticky_clr", 64'(sticky), 64'b00);
    clr = 1'b0;
    wr_en = 1'b1; wr_data = wd(0, 1, 24'h600);
    step();
    wr_en = 1'b0;
    step();
    check("eol_head", 64'({valid, rd_data}), 64'({1'b1, wd(0,1,24'h600)}));
    ready = 1'b1;
    step();
    check("eol_read", 64'(valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("eol_nounf%0d", i), 64'(unf), 64'd0);
    end
    check("eol_sticky", 64'(sticky), 64'b00);
    ready = 1'b0;

    // width conversion, sideband bits preserved
    t_wr_en = 1'b1; t_wr = {3'b110, 10'h3FF};
    p_wr_en = 1'b1; p_wr = {3'b011, 8'hAB};
    step();
    t_wr = {3'b001, 10'h2C5};
    p_wr = {3'b100, 8'h5F};
    step();
    t_wr_en = 1'b0; p_wr_en = 1'b0;
    check("trim_w0", 64'({t_valid, t_rd}), 64'({1'b1, 3'b110, 8'hFF}));
    check("pad_w0", 64'({p_valid, p_rd}), 64'({1'b1, 3'b011, 16'h02AC}));
    t_ready = 1'b1; p_ready = 1'b1;
    step();
    check("trim_w1", 64'({t_valid, t_rd}), 64'({1'b1, 3'b001, 8'hB1}));
    check("pad_w1", 64'({p_valid, p_rd}), 64'({1'b1, 3'b100, 16'h017C}));
    step();
    check("conv_drained", 64'({t_valid, p_valid, t_cnt, p_cnt}), 64'd0);
    t_ready = 1'b0; p_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
